// File: rtl/stopwatch_pkg.sv
// Stopwatch shared definitions.
//   sw_state_t : controller state encoding
//   DIGIT_W    : width of one BCD digit
//   digit_mod  : modulus of digit idx (6 on odd digits in MM:SS mode, else 10)
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_PAUSE  = 3'd2,
        ST_ADJUST = 3'd3,
        ST_DONE   = 3'd4
    } sw_state_t;

    localparam int DIGIT_W = 4;

    function automatic logic [DIGIT_W-1:0] digit_mod(input int idx, input int sexagesimal);
        if (sexagesimal != 0 && (idx % 2) == 1) begin
            return 4'd6;
        end
        return 4'd10;
    endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD digit of the stopwatch count.
//   clk, rst_n         : clock, async active-low reset
//   clr                : synchronous zero (highest priority)
//   load, load_val     : synchronous load (caller guarantees load_val < modulus)
//   inc, dec           : step up / down by one, wrapping at modulus
//   modulus            : digit modulus (6 or 10)
//   value, value_nxt   : registered digit and the value it takes at the next edge
//   carry, borrow      : this digit wraps on this step; feeds the next digit's inc/dec
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               inc,
    input  logic               dec,
    input  logic [DIGIT_W-1:0] modulus,
    output logic [DIGIT_W-1:0] value,
    output logic [DIGIT_W-1:0] value_nxt,
    output logic               carry,
    output logic               borrow
);

    always_comb begin
        value_nxt = value;
        carry     = 1'b0;
        borrow    = 1'b0;
        if (clr) begin
            value_nxt = '0;
        end else if (load) begin
            value_nxt = load_val;
        end else if (inc) begin
            if (value == modulus - 4'd1) begin
                value_nxt = '0;
                carry     = 1'b1;
            end else begin
                value_nxt = value + 4'd1;
            end
        end else if (dec) begin
            if (value == '0) begin
                value_nxt = modulus - 4'd1;
                borrow    = 1'b1;
            end else begin
                value_nxt = value - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else begin
            value <= value_nxt;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: prescaled BCD up/down counter with run/pause, digit adjust,
// countdown alarm and lap freeze.
//   clk, rst_n   : clock, async active-low reset
//   clear        : pulse, zero everything and return to IDLE
//   start_stop   : pulse, run/pause toggle (DONE -> IDLE)
//   lap          : pulse, freeze / release the lap display
//   count_down   : direction, sampled at each tick
//   adj_en       : level, adjust mode; adj_sel/adj_val pick digit and value
//   count, disp  : live count and displayed value (lap value while frozen)
//   running, lap_hold, alarm : status flags
//
// state     | meaning
// ST_IDLE   | stopped after reset/clear/alarm acknowledge
// ST_RUN    | prescaler active, count steps every TICK_DIV cycles
// ST_PAUSE  | stopped, count held
// ST_ADJUST | digits loadable from adj_sel/adj_val
// ST_DONE   | countdown reached zero, alarm raised
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 1_000_000,
    parameter int SEXAGESIMAL = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          start_stop,
    input  logic                          lap,
    input  logic                          count_down,
    input  logic                          adj_en,
    input  logic [2:0]                    adj_sel,
    input  logic [3:0]                    adj_val,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic [DIGIT_W*NUM_DIGITS-1:0] disp,
    output logic                          running,
    output logic                          lap_hold,
    output logic                          alarm
);

    localparam int CNT_W = DIGIT_W * NUM_DIGITS;
    localparam int PSC_W = $clog2(TICK_DIV);

    sw_state_t         state_q, state_nxt;
    logic [PSC_W-1:0]  psc_q, psc_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt, lap_q, lap_nxt, disp_q;
    logic              lap_hold_q, lap_hold_nxt, running_q, alarm_q;
    logic              tick, cnt_zero, cnt_one, adj_go;
    logic [NUM_DIGITS:0] carry_c, borrow_c;
    logic              chain_unused;

    assign cnt_zero = (cnt_q == '0);
    assign cnt_one  = (cnt_q == CNT_W'(1));

    // Tick is suppressed by any higher-priority event in the same cycle.
    assign tick   = (state_q == ST_RUN) && (psc_q == PSC_W'(TICK_DIV - 1))
                    && !clear && !adj_en && !start_stop;
    assign adj_go = (state_q == ST_ADJUST) && adj_en && !clear;

    // A down tick from all-zero is never applied; such a tick goes straight to DONE.
    assign carry_c[0]  = tick && !count_down;
    assign borrow_c[0] = tick && count_down && !cnt_zero;

    // Wrap out of the most significant digit has no consumer.
    assign chain_unused = carry_c[NUM_DIGITS] | borrow_c[NUM_DIGITS];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        localparam logic [DIGIT_W-1:0] MOD = digit_mod(i, SEXAGESIMAL);
        logic ld;
        assign ld = adj_go && (adj_sel == 3'(i)) && (adj_val < MOD);

        bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clear),
            .load      (ld),
            .load_val  (adj_val),
            .inc       (carry_c[i]),
            .dec       (borrow_c[i]),
            .modulus   (MOD),
            .value     (cnt_q[DIGIT_W*i +: DIGIT_W]),
            .value_nxt (cnt_nxt[DIGIT_W*i +: DIGIT_W]),
            .carry     (carry_c[i+1]),
            .borrow    (borrow_c[i+1])
        );
    end

    always_comb begin
        state_nxt = state_q;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else if (adj_en) begin
            state_nxt = ST_ADJUST;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (start_stop && !(count_down && cnt_zero)) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (start_stop) begin
                        state_nxt = ST_PAUSE;
                    end else if (tick && count_down && (cnt_one || cnt_zero)) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_ADJUST: state_nxt = ST_PAUSE;
                ST_DONE: begin
                    if (start_stop) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Prescaler only advances while staying in RUN, so it restarts from zero on every entry.
    always_comb begin
        psc_nxt = '0;
        if (state_q == ST_RUN && state_nxt == ST_RUN) begin
            psc_nxt = (psc_q == PSC_W'(TICK_DIV - 1)) ? '0 : psc_q + 1'b1;
        end
    end

    // Lap captures the registered (pre-tick) count.
    always_comb begin
        lap_hold_nxt = lap_hold_q;
        lap_nxt      = lap_q;
        if (clear) begin
            lap_hold_nxt = 1'b0;
            lap_nxt      = '0;
        end else if (lap) begin
            if (!lap_hold_q) begin
                lap_nxt      = cnt_q;
                lap_hold_nxt = 1'b1;
            end else begin
                lap_hold_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            psc_q      <= '0;
            lap_q      <= '0;
            lap_hold_q <= 1'b0;
            disp_q     <= '0;
            running_q  <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            psc_q      <= psc_nxt;
            lap_q      <= lap_nxt;
            lap_hold_q <= lap_hold_nxt;
            disp_q     <= lap_hold_nxt ? lap_nxt : cnt_nxt;
            running_q  <= (state_nxt == ST_RUN);
            alarm_q    <= (state_nxt == ST_DONE);
        end
    end

    assign count    = cnt_q;
    assign disp     = disp_q;
    assign running  = running_q;
    assign lap_hold = lap_hold_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        count_down = 1'b0;
    logic        adj_en = 1'b0;
    logic [2:0]  adj_sel = '0;
    logic [3:0]  adj_val = '0;
    logic [15:0] count, disp;
    logic        running, lap_hold, alarm;

    int total_cnt = 0;
    int bad_cnt   = 0;

    stopwatch_core #(
        .NUM_DIGITS  (4),
        .TICK_DIV    (4),
        .SEXAGESIMAL (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .start_stop (start_stop),
        .lap        (lap),
        .count_down (count_down),
        .adj_en     (adj_en),
        .adj_sel    (adj_sel),
        .adj_val    (adj_val),
        .count      (count),
        .disp       (disp),
        .running    (running),
        .lap_hold   (lap_hold),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clr();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
    endtask

    task automatic set_digit(input int sel, input int val);
        adj_sel = 3'(sel);
        adj_val = 4'(val);
        cyc(1);
    endtask

    initial begin
        // reset state, no clock edge needed
        #3;
        check("rst_count", 32'(count), 32'h0);
        check("rst_disp", 32'(disp), 32'h0);
        check("rst_flags", {29'd0, running, lap_hold, alarm}, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // run 240 cycles at TICK_DIV=4 -> 60 s -> 01:00
        pulse_ss();
        check("run_flag", 32'(running), 32'h1);
        cyc(3);
        check("pre_tick", 32'(count), 32'h0);
        cyc(1);
        check("first_tick", 32'(count), 32'h1);
        cyc(236);
        check("one_minute", 32'(count), 32'h0100);
        pulse_ss();
        cyc(6);
        check("pause_hold", {15'd0, running, count}, {15'd0, 1'b0, 16'h0100});
        pulse_clr();
        check("clear_cnt", 32'(count), 32'h0);

        // 59:59 up -> 00:00 wrap, with two invalid loads ignored
        adj_en = 1'b1;
        cyc(1);
        set_digit(0, 9);
        set_digit(1, 5);
        set_digit(2, 9);
        set_digit(3, 5);
        set_digit(3, 7);
        set_digit(5, 1);
        adj_en = 1'b0;
        cyc(1);
        check("adj_5959", 32'(count), 32'h5959);
        pulse_ss();
        cyc(4);
        check("wrap_cnt", 32'(count), 32'h0);
        check("wrap_flags", {30'd0, running, alarm}, {30'd0, 1'b1, 1'b0});
        pulse_clr();

        // countdown from 3 s to alarm
        adj_en = 1'b1;
        cyc(1);
        set_digit(0, 3);
        set_digit(1, 6);
        check("adj_invalid", 32'(count), 32'h0003);
        adj_en = 1'b0;
        cyc(1);
        count_down = 1'b1;
        pulse_ss();
        cyc(8);
        check("down_one", {30'd0, alarm, 1'b0} | (32'(count) << 4), 32'h10);
        cyc(4);
        check("down_zero", 32'(count), 32'h0);
        check("done_flags", {30'd0, running, alarm}, {30'd0, 1'b0, 1'b1});
        pulse_ss();
        check("ack_idle", {30'd0, running, alarm}, 32'h0);
        pulse_ss();
        cyc(2);
        check("zero_start_ignored", 32'(running), 32'h0);
        count_down = 1'b0;

        // lap freeze / release at 00:12
        pulse_clr();
        adj_en = 1'b1;
        cyc(1);
        set_digit(1, 1);
        set_digit(0, 2);
        adj_en = 1'b0;
        cyc(1);
        pulse_ss();
        pulse_lap();
        check("lap_hold_set", {15'd0, lap_hold, disp}, {15'd0, 1'b1, 16'h0012});
        cyc(8);
        check("lap_frozen", {count, disp}, {16'h0014, 16'h0012});
        pulse_lap();
        check("lap_release", {15'd0, lap_hold, disp}, {15'd0, 1'b0, 16'h0014});
        cyc(3);
        check("disp_tracks", {count, disp}, {16'h0015, 16'h0015});
        cyc(2);
        pulse_lap();
        check("lap_on_tick", {count, disp}, {16'h0016, 16'h0015});

        // clear beats start_stop, and drops the lap
        clear = 1'b1;
        start_stop = 1'b1;
        cyc(1);
        clear = 1'b0;
        start_stop = 1'b0;
        check("clr_prio", {13'd0, running, lap_hold, alarm, count}, 32'h0);
        check("clr_disp", 32'(disp), 32'h0);

        // async reset mid-run
        pulse_ss();
        cyc(7);
        check("pre_reset_cnt", 32'(count), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", {running, lap_hold, alarm, count, disp}, 35'h0);
        #2;
        rst_n = 1'b1;
        cyc(6);
        check("post_reset", {15'd0, running, count}, 32'h0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
